// File: rtl/passcode_fsm_param_if.sv
// Passcode checker bus: raw button, switch digit, alarm-FSM controls in;
// unlock/progress/status out. master = driver of inputs, slave = checker.
interface passcode_fsm_param_if #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4,
    parameter int FCW     = 2
);
    logic               btn_n;
    logic [DIGIT_W-1:0] digit_in;
    logic               arm_en;
    logic               clear;
    logic               prog_req;
    logic               passcode_correct;
    logic [DIGITS-1:0]  progress;
    logic [FCW-1:0]     fail_count;
    logic               locked_out;
    logic               prog_active;
    logic               timeout_pulse;

    modport master (
        output btn_n, digit_in, arm_en, clear, prog_req,
        input  passcode_correct, progress, fail_count,
        input  locked_out, prog_active, timeout_pulse
    );

    modport slave (
        input  btn_n, digit_in, arm_en, clear, prog_req,
        output passcode_correct, progress, fail_count,
        output locked_out, prog_active, timeout_pulse
    );
endinterface

// File: rtl/passcode_fsm_param.sv
// Parametrised passcode checker: button sync/one-shot, timeout, lockout,
// run-time reprogramming. Ports: clk, reset_n (sync, active-low), bus (slave).
module passcode_fsm_param #(
    parameter int                        DIGITS       = 4,
    parameter int                        DIGIT_W      = 4,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1224,
    parameter bit                        EARLY_REJECT = 1'b1,
    parameter int                        TIMEOUT_CYC  = 50_000_000,
    parameter int                        MAX_FAILS    = 3,
    parameter int                        LOCKOUT_CYC  = 500_000_000
) (
    input logic                 clk,
    input logic                 reset_n,
    passcode_fsm_param_if.slave bus
);
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam int LW  = $clog2(LOCKOUT_CYC + 1);
    localparam int FCW = $clog2(MAX_FAILS + 1);
    localparam logic [IW-1:0]  LAST  = IW'(DIGITS - 1);
    localparam logic [TW-1:0]  TMAX  = TW'(TIMEOUT_CYC);
    localparam logic [LW-1:0]  LLAST = LW'(LOCKOUT_CYC - 1);
    localparam logic [FCW-1:0] FMAX  = FCW'(MAX_FAILS);

    typedef enum logic [2:0] {
        IDLE, ENTRY, UNLOCKED, PROGRAM, LOCKOUT
    } state_t;

    state_t state_q, state_d;
    // Digit 0 sits in the top slice so the code reads left to right.
    logic [DIGITS-1:0][DIGIT_W-1:0] code_q, code_d, shad_q, shad_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              mis_q, mis_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [LW-1:0]     lcnt_q, lcnt_d;
    logic [FCW-1:0]    fails_q, fails_d, fails_inc;
    logic              s1_q, s2_q, s3_q;
    logic              press, dig_bad, mis_now, expired, fail_lock;
    logic              tpulse_q, tpulse_d;
    logic              correct_q, lock_q, pact_q;
    logic [DIGITS-1:0] prog_q, prog_d;

    assign press     = s2_q & ~s3_q;
    assign dig_bad   = bus.digit_in != code_q[LAST - idx_q];
    assign mis_now   = mis_q | dig_bad;
    assign expired   = tcnt_q == TMAX;
    assign fails_inc = (fails_q == FMAX) ? fails_q : fails_q + 1'b1;
    assign fail_lock = fails_inc == FMAX;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        shad_d   = shad_q;
        idx_d    = idx_q;
        mis_d    = mis_q;
        fails_d  = fails_q;
        tcnt_d   = expired ? tcnt_q : tcnt_q + 1'b1;
        lcnt_d   = '0;
        tpulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                idx_d  = '0;
                mis_d  = 1'b0;
                tcnt_d = '0;
                if (press && bus.arm_en) begin
                    if (EARLY_REJECT && dig_bad) begin
                        fails_d = fails_inc;
                        if (fail_lock) state_d = LOCKOUT;
                    end else begin
                        state_d = ENTRY;
                        idx_d   = IW'(1);
                        mis_d   = dig_bad;
                    end
                end
            end
            ENTRY: begin
                // Disarming aborts silently; a press beats expiry.
                if (!bus.arm_en) begin
                    state_d = IDLE;
                end else if (press) begin
                    tcnt_d = '0;
                    idx_d  = idx_q + 1'b1;
                    mis_d  = mis_now;
                    if ((EARLY_REJECT && dig_bad) ||
                        (idx_q == LAST && mis_now)) begin
                        fails_d = fails_inc;
                        state_d = fail_lock ? LOCKOUT : IDLE;
                    end else if (idx_q == LAST) begin
                        fails_d = '0;
                        state_d = UNLOCKED;
                    end
                end else if (expired) begin
                    state_d  = IDLE;
                    tpulse_d = 1'b1;
                end
            end
            UNLOCKED: begin
                idx_d  = '0;
                tcnt_d = '0;
                if (bus.clear) begin
                    state_d = IDLE;
                end else if (bus.prog_req) begin
                    state_d = PROGRAM;
                end
            end
            PROGRAM: begin
                if (press) begin
                    tcnt_d = '0;
                    idx_d  = idx_q + 1'b1;
                    shad_d[LAST - idx_q] = bus.digit_in;
                    if (idx_q == LAST) begin
                        code_d  = shad_d;
                        state_d = UNLOCKED;
                    end
                end else if (expired) begin
                    state_d  = UNLOCKED;
                    tpulse_d = 1'b1;
                end
            end
            LOCKOUT: begin
                if (lcnt_q == LLAST) begin
                    state_d = IDLE;
                    fails_d = '0;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prog_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            prog_d[i] = (state_d == ENTRY || state_d == PROGRAM) &&
                        (i < int'(idx_d));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            code_q    <= DEFAULT_CODE;
            shad_q    <= '0;
            idx_q     <= '0;
            mis_q     <= 1'b0;
            tcnt_q    <= '0;
            lcnt_q    <= '0;
            fails_q   <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            tpulse_q  <= 1'b0;
            correct_q <= 1'b0;
            lock_q    <= 1'b0;
            pact_q    <= 1'b0;
            prog_q    <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            shad_q    <= shad_d;
            idx_q     <= idx_d;
            mis_q     <= mis_d;
            tcnt_q    <= tcnt_d;
            lcnt_q    <= lcnt_d;
            fails_q   <= fails_d;
            s1_q      <= ~bus.btn_n;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            tpulse_q  <= tpulse_d;
            correct_q <= state_d == UNLOCKED;
            lock_q    <= state_d == LOCKOUT;
            pact_q    <= state_d == PROGRAM;
            prog_q    <= prog_d;
        end
    end

    assign bus.passcode_correct = correct_q;
    assign bus.progress         = prog_q;
    assign bus.fail_count       = fails_q;
    assign bus.locked_out       = lock_q;
    assign bus.prog_active      = pact_q;
    assign bus.timeout_pulse    = tpulse_q;
endmodule

// File: tb/tb_passcode_fsm_param.sv
// Self-checking bench for passcode_fsm_param: two instances (early and
// deferred reject) share one stimulus stream; progress uses a scoreboard.
module tb_passcode_fsm_param;
    localparam int TO  = 100;
    localparam int MF  = 3;
    localparam int LO  = 200;
    localparam int FCW = $clog2(MF + 1);

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_n = 1'b1;
    logic       arm_en = 1'b0;
    logic       clear = 1'b0;
    logic       prog_req = 1'b0;
    logic [3:0] digit_in = 4'h0;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    passcode_fsm_param_if #(.DIGITS(4), .DIGIT_W(4), .FCW(FCW)) b0 ();
    passcode_fsm_param_if #(.DIGITS(4), .DIGIT_W(4), .FCW(FCW)) b1 ();

    assign b0.btn_n    = btn_n;
    assign b0.digit_in = digit_in;
    assign b0.arm_en   = arm_en;
    assign b0.clear    = clear;
    assign b0.prog_req = prog_req;
    assign b1.btn_n    = btn_n;
    assign b1.digit_in = digit_in;
    assign b1.arm_en   = arm_en;
    assign b1.clear    = clear;
    assign b1.prog_req = prog_req;

    passcode_fsm_param #(
        .DIGITS(4), .DIGIT_W(4), .DEFAULT_CODE(16'h1224),
        .EARLY_REJECT(1'b1), .TIMEOUT_CYC(TO),
        .MAX_FAILS(MF), .LOCKOUT_CYC(LO)
    ) dut0 (.clk(clk), .reset_n(reset_n), .bus(b0.slave));

    passcode_fsm_param #(
        .DIGITS(4), .DIGIT_W(4), .DEFAULT_CODE(16'h1224),
        .EARLY_REJECT(1'b0), .TIMEOUT_CYC(TO),
        .MAX_FAILS(MF), .LOCKOUT_CYC(LO)
    ) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        btn_n    = 1'b1;
        clear    = 1'b0;
        prog_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Returns on the negedge after the FSM edge that consumes the press.
    task automatic press(input logic [3:0] d);
        @(negedge clk);
        btn_n    = 1'b0;
        digit_in = d;
        repeat (3) @(negedge clk);
        btn_n = 1'b1;
    endtask

    task automatic enter(input logic [15:0] c);
        for (int i = 0; i < 4; i++) press(c[15-4*i -: 4]);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({b0.passcode_correct, b0.locked_out, b0.prog_active,
             b0.timeout_pulse, b0.fail_count, b0.progress} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got pc=%b lo=%b pa=%b tp=%b fc=%0d pr=%b exp all 0",
                     b0.passcode_correct, b0.locked_out, b0.prog_active,
                     b0.timeout_pulse, b0.fail_count, b0.progress);
        end
    endtask

    task automatic test_correct();
        logic [15:0] c = 16'h1224;
        logic [3:0]  e;
        do_reset();
        arm_en = 1'b1;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b0000);
        for (int i = 0; i < 4; i++) begin
            press(c[15-4*i -: 4]);
            e = exp_q.pop_front();
            checks++;
            if (b0.progress !== e) begin
                errors++;
                $display("FAIL correct_progress[%0d] got %b exp %b", i, b0.progress, e);
            end
        end
        checks++;
        if (b0.passcode_correct !== 1'b1) begin
            errors++;
            $display("FAIL correct_unlock got %b exp 1", b0.passcode_correct);
        end
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        checks++;
        if (b0.passcode_correct !== 1'b0) begin
            errors++;
            $display("FAIL correct_clear got %b exp 0", b0.passcode_correct);
        end
    endtask

    task automatic test_held();
        do_reset();
        arm_en = 1'b1;
        @(negedge clk);
        btn_n    = 1'b0;
        digit_in = 4'h1;
        repeat (50) @(negedge clk);
        checks++;
        if (b0.progress !== 4'b0001) begin
            errors++;
            $display("FAIL held_single got %b exp 0001", b0.progress);
        end
        btn_n = 1'b1;
        press(4'h2);
        checks++;
        if (b0.progress !== 4'b0011) begin
            errors++;
            $display("FAIL held_next got %b exp 0011", b0.progress);
        end
    endtask

    task automatic test_arm();
        do_reset();
        arm_en = 1'b0;
        press(4'h1);
        checks++;
        if (b0.progress !== 4'b0000) begin
            errors++;
            $display("FAIL arm_ignored got %b exp 0000", b0.progress);
        end
        arm_en = 1'b1;
        press(4'h1);
        @(negedge clk) arm_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({b0.progress, b0.fail_count} !== 6'd0) begin
            errors++;
            $display("FAIL arm_abort got pr=%b fc=%0d exp 0000/0", b0.progress, b0.fail_count);
        end
    endtask

    task automatic test_reject();
        do_reset();
        arm_en = 1'b1;
        press(4'h1);
        press(4'h3);
        checks++;
        if ({b0.progress, b0.fail_count} !== {4'b0000, 2'd1}) begin
            errors++;
            $display("FAIL early_reject got pr=%b fc=%0d exp 0000/1", b0.progress, b0.fail_count);
        end
        checks++;
        if ({b1.progress, b1.fail_count} !== {4'b0011, 2'd0}) begin
            errors++;
            $display("FAIL deferred_2nd got pr=%b fc=%0d exp 0011/0", b1.progress, b1.fail_count);
        end
        press(4'h2);
        checks++;
        if (b1.progress !== 4'b0111) begin
            errors++;
            $display("FAIL deferred_3rd got %b exp 0111", b1.progress);
        end
        press(4'h4);
        checks++;
        if ({b1.progress, b1.fail_count, b1.passcode_correct} !== {4'b0000, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL deferred_4th got pr=%b fc=%0d pc=%b exp 0000/1/0",
                     b1.progress, b1.fail_count, b1.passcode_correct);
        end
    endtask

    task automatic test_lockout();
        do_reset();
        arm_en = 1'b1;
        press(4'h5);
        press(4'h5);
        checks++;
        if ({b0.locked_out, b0.fail_count} !== {1'b0, 2'd2}) begin
            errors++;
            $display("FAIL lock_pre got lo=%b fc=%0d exp 0/2", b0.locked_out, b0.fail_count);
        end
        press(4'h5);
        checks++;
        if ({b0.locked_out, b0.fail_count} !== {1'b1, 2'd3}) begin
            errors++;
            $display("FAIL lock_enter got lo=%b fc=%0d exp 1/3", b0.locked_out, b0.fail_count);
        end
        press(4'h1);
        press(4'h1);
        checks++;
        if ({b0.locked_out, b0.progress} !== {1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL lock_ignore got lo=%b pr=%b exp 1/0000", b0.locked_out, b0.progress);
        end
        repeat (LO - 9) @(negedge clk);
        checks++;
        if (b0.locked_out !== 1'b1) begin
            errors++;
            $display("FAIL lock_last_cycle got %b exp 1", b0.locked_out);
        end
        @(negedge clk);
        checks++;
        if ({b0.locked_out, b0.fail_count} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL lock_exit got lo=%b fc=%0d exp 0/0", b0.locked_out, b0.fail_count);
        end
        press(4'h1);
        checks++;
        if (b0.progress !== 4'b0001) begin
            errors++;
            $display("FAIL lock_after got %b exp 0001", b0.progress);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        arm_en = 1'b1;
        press(4'h1);
        repeat (TO) @(negedge clk);
        checks++;
        if ({b0.timeout_pulse, b0.progress} !== {1'b0, 4'b0001}) begin
            errors++;
            $display("FAIL to_before got tp=%b pr=%b exp 0/0001", b0.timeout_pulse, b0.progress);
        end
        @(negedge clk);
        checks++;
        if ({b0.timeout_pulse, b0.progress, b0.fail_count} !== {1'b1, 4'b0000, 2'd0}) begin
            errors++;
            $display("FAIL to_expire got tp=%b pr=%b fc=%0d exp 1/0000/0",
                     b0.timeout_pulse, b0.progress, b0.fail_count);
        end
        @(negedge clk);
        checks++;
        if (b0.timeout_pulse !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse_width got %b exp 0", b0.timeout_pulse);
        end
        press(4'h1);
        repeat (TO - 3) @(negedge clk);
        press(4'h2);
        checks++;
        if ({b0.timeout_pulse, b0.progress} !== {1'b0, 4'b0011}) begin
            errors++;
            $display("FAIL to_press_wins got tp=%b pr=%b exp 0/0011", b0.timeout_pulse, b0.progress);
        end
    endtask

    task automatic test_reprogram();
        logic [15:0] c = 16'h9876;
        logic [3:0]  e;
        do_reset();
        arm_en = 1'b1;
        enter(16'h1224);
        @(negedge clk) prog_req = 1'b1;
        @(negedge clk) prog_req = 1'b0;
        checks++;
        if ({b0.prog_active, b0.passcode_correct} !== 2'b10) begin
            errors++;
            $display("FAIL prog_enter got pa=%b pc=%b exp 1/0", b0.prog_active, b0.passcode_correct);
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b0000);
        for (int i = 0; i < 4; i++) begin
            press(c[15-4*i -: 4]);
            e = exp_q.pop_front();
            checks++;
            if (b0.progress !== e) begin
                errors++;
                $display("FAIL prog_progress[%0d] got %b exp %b", i, b0.progress, e);
            end
        end
        checks++;
        if ({b0.prog_active, b0.passcode_correct} !== 2'b01) begin
            errors++;
            $display("FAIL prog_done got pa=%b pc=%b exp 0/1", b0.prog_active, b0.passcode_correct);
        end
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        enter(16'h9876);
        checks++;
        if (b0.passcode_correct !== 1'b1) begin
            errors++;
            $display("FAIL new_code_unlock got %b exp 1", b0.passcode_correct);
        end
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        press(4'h1);
        checks++;
        if (b0.fail_count !== 2'd1) begin
            errors++;
            $display("FAIL old_code_rejected got %0d exp 1", b0.fail_count);
        end
        press(4'h9);
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        checks++;
        if ({b0.progress, b0.fail_count} !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset got pr=%b fc=%0d exp 0000/0", b0.progress, b0.fail_count);
        end
        enter(16'h1224);
        checks++;
        if (b0.passcode_correct !== 1'b1) begin
            errors++;
            $display("FAIL default_restored got %b exp 1", b0.passcode_correct);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_held();
        test_arm();
        test_reject();
        test_lockout();
        test_timeout();
        test_reprogram();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/passcode_fsm_param.md
Name: passcode_fsm_param

Overview:
- Parametrised successor to the fixed 4-digit passcode checker in the alarm system.
- Digit count, digit width and stored code are configurable; the code is reprogrammable at run time while unlocked.
- Includes a built-in button synchroniser/one-shot, an internal inter-digit timeout, an optional deferred-reject mode and a failed-attempt lockout.
- Sits between the board switches/button and the top-level alarm FSM, which supplies arm_en/clear and consumes passcode_correct.

Parameters:
DIGITS, 4, number of digits per code (2..8)
DIGIT_W, 4, width of one digit (switch bank width)
DEFAULT_CODE, 16'h1224, reset code, DIGITS*DIGIT_W bits; first digit in MSBs
EARLY_REJECT, 1, 1 = return to IDLE on first wrong digit; 0 = collect all DIGITS, then decide
TIMEOUT_CYC, 50_000_000, clk cycles allowed between accepted presses
MAX_FAILS, 3, consecutive failures that trigger lockout (>=1)
LOCKOUT_CYC, 500_000_000, lockout duration in clk cycles

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
btn_n  input  1  raw entry button, active-low, asynchronous to clk
digit_in  input  DIGIT_W  switch value, sampled on a press event
arm_en  input  1  entry permitted (alarm set or triggered)
clear  input  1  alarm FSM has registered success; UNLOCKED returns to IDLE
prog_req  input  1  in UNLOCKED, start programming a new code
passcode_correct  output  1  high while in UNLOCKED
progress  output  DIGITS  thermometer of digits entered in current attempt
fail_count  output  $clog2(MAX_FAILS+1)  consecutive failures
locked_out  output  1  high while in LOCKOUT
prog_active  output  1  high while in PROGRAM
timeout_pulse  output  1  one-cycle pulse on inter-digit timeout

Behaviour:
- Reset (reset_n low at a clk edge): state=IDLE; stored code=DEFAULT_CODE; all outputs 0; synchroniser flops cleared; all counters 0. Reset overrides everything, including mid-entry, mid-lockout and mid-program.
- Button: pressed = ~btn_n passes through 2-flop sync s1,s2, then delay flop s3. press = s2 & ~s3.
  - If btn_n is low at edge k, the FSM acts on the press at edge k+2.
  - Exactly one press per falling edge of btn_n, however long the button is held.
- digit_in is sampled in the same cycle press is high.
- States: IDLE, ENTRY, UNLOCKED, PROGRAM, LOCKOUT.
- Counters: idx, 0..DIGITS-1. mismatch flag: sticky OR of per-digit compare failures.
- IDLE:
  - press with arm_en=1: compare digit_in against code digit 0, set idx=1.
  - EARLY_REJECT=1 and mismatch: count a failure, stay IDLE.
  - Otherwise: go to ENTRY.
  - press with arm_en=0: ignored.
- ENTRY:
  - Each press compares against code digit idx.
  - EARLY_REJECT=1 and mismatch: failure -> IDLE.
  - On the last digit (idx=DIGITS-1): no mismatch -> UNLOCKED with fail_count=0; any mismatch -> failure -> IDLE.
  - arm_en falling: abort to IDLE, not counted as a failure.
- Timeout: a counter reloads on entry to ENTRY and on each accepted press. When it reaches TIMEOUT_CYC with no press: go to IDLE, pulse timeout_pulse for 1 cycle, no failure counted. A press and expiry in the same cycle: the press wins.
- Failure: fail_count++. When fail_count reaches MAX_FAILS -> LOCKOUT instead of IDLE.
- LOCKOUT: presses ignored. After LOCKOUT_CYC cycles -> IDLE with fail_count=0.
- UNLOCKED:
  - passcode_correct=1.
  - clear=1 -> IDLE; clear has priority over prog_req.
  - prog_req=1 -> PROGRAM, idx=0.
- PROGRAM:
  - Each press writes digit_in into a shadow register at idx.
  - After DIGITS presses, shadow is copied to the stored code in one cycle -> UNLOCKED.
  - Timeout in PROGRAM discards the shadow -> UNLOCKED; the stored code is unchanged.
- progress: bit i = 1 when i < number of digits accepted in current ENTRY/PROGRAM. Cleared in every other state.
- passcode_correct, locked_out and prog_active are registered decodes of state. All outputs are registered.
- Width rules:
  - Timeout and lockout counters are sized $clog2(max value + 1) and saturate; they never wrap.
  - fail_count saturates at MAX_FAILS.

Test Plan (DIGITS=4, DIGIT_W=4, DEFAULT_CODE=16'h1224, TIMEOUT_CYC=100, MAX_FAILS=3, LOCKOUT_CYC=200):
1. Correct entry: arm_en=1, press digits 1,2,2,4 -> progress 0001,0011,0111, then passcode_correct=1 two cycles after the 4th btn_n fall; clear=1 -> IDLE, passcode_correct=0.
2. Held button: btn_n held low 50 cycles with digit 1 -> progress=0001 only, single press registered.
3. EARLY_REJECT=1: press 1,3 -> IDLE, fail_count=1. Rerun with EARLY_REJECT=0: press 1,3,2,4 -> IDLE only after the 4th press, fail_count=1.
4. Lockout: three wrong attempts -> locked_out=1; presses are ignored for 200 cycles; then IDLE, fail_count=0.
5. Timeout: press 1, wait 100 cycles -> timeout_pulse for 1 cycle, IDLE, fail_count unchanged; a press on the expiry cycle instead advances to progress=0011.
6. Reprogram: in UNLOCKED, prog_req, press 9,8,7,6 -> UNLOCKED; clear; code 9876 unlocks and 1224 fails. reset_n low mid-sequence -> DEFAULT_CODE restored.
